approx_mult_iter: RTL and testbench

//  Iterative, parametrised WxW unsigned multiplier. One 4x4 nibble multiplier is reused
//  for all (W/4)^2 partial products, one per cycle, into a 2W-bit accumulator.

---
 rtl/approx_mult_pkg.sv | 44 ++++
 rtl/nib_mult_4x4.sv | 21 ++
 rtl/approx_mult_iter.sv | 113 +++++++++++
 tb/tb_approx_mult_iter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared constants, FSM encoding and the LM_1_EC arithmetic helpers for the
// iterative approximate multiplier.
package approx_mult_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] MODE_EXACT      = 2'b00;
    localparam logic [1:0] MODE_THRESH     = 2'b01;
    localparam logic [1:0] MODE_ALL_APPROX = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [1:0] lead_one(input logic [NIB_W-1:0] v);
        if (v[3]) return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else return 2'd0;
    endfunction

    function automatic logic [NIB_W-1:0] residue(input logic [NIB_W-1:0] v);
        logic [NIB_W-1:0] mask;
        mask = 4'b0001 << lead_one(v);
        return v & ~mask;
    endfunction

    // Mitchell log-domain product: 2^(kx+ky) + rx*2^ky + ry*2^kx, never above x*y.
    function automatic logic [2*NIB_W-1:0] lm_base(input logic [NIB_W-1:0] x,
                                                    input logic [NIB_W-1:0] y);
        logic [1:0]         kx;
        logic [1:0]         ky;
        logic [2*NIB_W-1:0] t;
        if (x == '0 || y == '0) return '0;
        kx = lead_one(x);
        ky = lead_one(y);
        t  = 8'd1 << ({1'b0, kx} + {1'b0, ky});
        t  = t + ({4'b0000, residue(x)} << ky) + ({4'b0000, residue(y)} << kx);
        return t;
    endfunction

endpackage

// File: rtl/nib_mult_4x4.sv
// Combinational 4x4 nibble multiplier: exact product or LM_1_EC approximation
// (Mitchell product plus one Mitchell correction of the residues), chosen by sel.
module nib_mult_4x4
    import approx_mult_pkg::*;
(
    input  logic [NIB_W-1:0]   x,
    input  logic [NIB_W-1:0]   y,
    input  logic               sel,
    output logic [2*NIB_W-1:0] p
);

    logic [2*NIB_W-1:0] exact_p;
    logic [2*NIB_W-1:0] approx_p;

    always_comb begin
        exact_p  = {4'b0000, x} * {4'b0000, y};
        approx_p = lm_base(x, y) + lm_base(residue(x), residue(y));
        p        = sel ? approx_p : exact_p;
    end

endmodule

// File: rtl/approx_mult_iter.sv
// Iterative WxW unsigned multiplier reusing one nibble multiplier for all
// (W/4)^2 partial products, with valid/ready handshakes on both sides.
module approx_mult_iter
    import approx_mult_pkg::*;
#(
    parameter int W            = 8,
    parameter int APPROX_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] r
);

    localparam int N  = W / NIB_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [1:0]           mode_q;
    logic [CW-1:0]        i;
    logic [CW-1:0]        j;
    logic [2*W-1:0]       acc;
    logic [2*W-1:0]       acc_next;
    logic [2*W-1:0]       pp_shifted;
    logic [CW:0]          ij_sum;
    logic [NIB_W-1:0]     a_nib;
    logic [NIB_W-1:0]     b_nib;
    logic                 sel;
    logic [2*NIB_W-1:0]   pp;

    // Select the current nibble pair, decide approximation and shift into place.
    always_comb begin
        ij_sum = {1'b0, i} + {1'b0, j};
        a_nib  = a_q[{i, 2'b00} +: NIB_W];
        b_nib  = b_q[{j, 2'b00} +: NIB_W];
        case (mode_q)
            MODE_THRESH:     sel = (int'(ij_sum) < APPROX_DEPTH);
            MODE_ALL_APPROX: sel = 1'b1;
            default:         sel = 1'b0;
        endcase
        pp_shifted = {{(2*W-2*NIB_W){1'b0}}, pp} << {ij_sum, 2'b00};
        acc_next   = acc + pp_shifted;
    end

    nib_mult_4x4 u_nib (
        .x   (a_nib),
        .y   (b_nib),
        .sel (sel),
        .p   (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= MODE_EXACT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        mode_q   <= mode;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) state <= ST_DONE;
                        else           i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                // First DONE cycle publishes the result; it then holds until taken.
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        r         <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_iter.sv
// Directed and model-checked bench for approx_mult_iter at W=8 and W=16.
module tb_approx_mult_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [1:0]  mode8;
    logic [15:0] r8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [1:0]  mode16;
    logic [31:0] r16;

    int checks = 0;
    int errors = 0;

    approx_mult_iter #(.W(8), .APPROX_DEPTH(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .r(r8)
    );

    approx_mult_iter #(.W(16), .APPROX_DEPTH(2)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .r(r16)
    );

    // Reference LM_1_EC: Mitchell product plus Mitchell product of the residues.
    function automatic int msb4(input int v);
        int k;
        k = 0;
        for (int t = 0; t < 4; t++) if (v[t]) k = t;
        return k;
    endfunction

    function automatic int mitchell(input int x, input int y);
        int kx, ky;
        if (x == 0 || y == 0) return 0;
        kx = msb4(x);
        ky = msb4(y);
        return (1 << (kx + ky)) + ((x - (1 << kx)) << ky) + ((y - (1 << ky)) << kx);
    endfunction

    function automatic int lm1ec(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return mitchell(x, y) + mitchell(x - (1 << msb4(x)), y - (1 << msb4(y)));
    endfunction

    function automatic longint golden(input int w, input longint av, input longint bv,
                                      input int md, input int depth);
        longint acc;
        int     n, x, y, p;
        bit     ap;
        acc = 0;
        n = w / 4;
        for (int ii = 0; ii < n; ii++) begin
            for (int jj = 0; jj < n; jj++) begin
                x  = int'((av >> (4 * ii)) & 64'd15);
                y  = int'((bv >> (4 * jj)) & 64'd15);
                ap = (md == 2) || (md == 1 && (ii + jj) < depth);
                p  = ap ? lm1ec(x, y) : x * y;
                acc = acc + (longint'(p) << (4 * (ii + jj)));
            end
        end
        return acc & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] mv,
                          output logic [15:0] rv, output int lat);
        @(posedge clk); #1;
        a8 = av; b8 = bv; mode8 = mv; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rv = r8;
        @(posedge clk); #1;
    endtask

    task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] mv,
                           output logic [31:0] rv, output int lat);
        @(posedge clk); #1;
        a16 = av; b16 = bv; mode16 = mv; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rv = r16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready8 got %0b want 1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid8 got %0b want 0", out_valid8); end
        checks++; if (r8 !== 16'd0) begin errors++; $display("[TB] FAIL reset_r8 got %0d want 0", r8); end
        checks++; if (in_ready16 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready16 got %0b want 1", in_ready16); end
        checks++; if (out_valid16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid16 got %0b want 0", out_valid16); end
        checks++; if (r16 !== 32'd0) begin errors++; $display("[TB] FAIL reset_r16 got %0d want 0", r16); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exact_w8();
        logic [15:0] got;
        int lat, cnt;
        @(posedge clk); #1;
        a8 = 8'd255; b8 = 8'd255; mode8 = 2'b00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        got = r8;
        cnt = 0;
        while (out_valid8 && cnt < 10) begin @(posedge clk); #1; cnt++; end
        checks++; if (got !== 16'd65025) begin errors++; $display("[TB] FAIL exact8_ff_ff got %0d want 65025", got); end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL exact8_latency got %0d want 5", lat); end
        checks++; if (cnt != 1) begin errors++; $display("[TB] FAIL exact8_valid_width got %0d want 1", cnt); end
    endtask

    task automatic test_exact_w16();
        logic [31:0] got;
        logic [15:0] av, bv;
        int lat;
        do_op16(16'hFFFF, 16'h1234, 2'b00, got, lat);
        checks++; if (got !== 32'h1233EDCC) begin errors++; $display("[TB] FAIL exact16_ffff_1234 got %h want 1233edcc", got); end
        checks++; if (lat != 17) begin errors++; $display("[TB] FAIL exact16_latency got %0d want 17", lat); end
        do_op16(16'hFFFF, 16'hFFFF, 2'b11, got, lat);
        checks++; if (got !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL exact16_max got %h want fffe0001", got); end
        for (int n = 0; n < 200; n++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            do_op16(av, bv, 2'b00, got, lat);
            checks++;
            if (got !== 32'(av) * 32'(bv)) begin
                errors++;
                $display("[TB] FAIL exact16_random %h*%h got %h want %h", av, bv, got, 32'(av) * 32'(bv));
            end
        end
    endtask

    task automatic test_approx_directed();
        int va[7], vb[7], vm[7], ve[7];
        logic [15:0] got;
        int lat;
        va = '{255, 255, 211, 211, 15, 3, 255};
        vb = '{255, 255, 181, 181, 15, 5, 255};
        vm = '{2, 1, 2, 0, 2, 2, 0};
        ve = '{62424, 64728, 37935, 38191, 216, 15, 65025};
        for (int n = 0; n < 7; n++) begin
            do_op8(8'(va[n]), 8'(vb[n]), 2'(vm[n]), got, lat);
            checks++;
            if (got !== 16'(ve[n])) begin
                errors++;
                $display("[TB] FAIL approx_directed %0d*%0d mode %0d got %0d want %0d", va[n], vb[n], vm[n], got, ve[n]);
            end
        end
    endtask

    task automatic test_approx_random();
        logic [7:0]  av, bv;
        logic [1:0]  mv;
        logic [15:0] got, exp;
        int lat;
        for (int n = 0; n < 300; n++) begin
            av  = 8'($urandom);
            bv  = 8'($urandom);
            mv  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp = 16'(golden(8, longint'(av), longint'(bv), int'(mv), 2));
            do_op8(av, bv, mv, got, lat);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL approx_random %0d*%0d mode %0d got %0d want %0d", av, bv, mv, got, exp);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] got;
        int lat;
        for (int m = 0; m < 4; m++) begin
            do_op8(8'h00, 8'hB7, 2'(m), got, lat);
            checks++; if (got !== 16'd0) begin errors++; $display("[TB] FAIL zero_a mode %0d got %0d want 0", m, got); end
            do_op8(8'h9E, 8'h00, 2'(m), got, lat);
            checks++; if (got !== 16'd0) begin errors++; $display("[TB] FAIL zero_b mode %0d got %0d want 0", m, got); end
        end
    endtask

    task automatic test_backpressure();
        int lat, bad;
        out_ready8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'd77; b8 = 8'd91; mode8 = 2'b00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd12; b8 = 8'd34;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL bp_latency got %0d want 5", lat); end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid8 !== 1'b1 || r8 !== 16'd7007 || in_ready8 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold bad cycles %0d want 0 (r=%0d)", bad, r8); end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL bp_drop_valid got %0b want 0", out_valid8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_early_accept in_ready got %0b want 1", in_ready8); end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept_next in_ready got %0b want 0", in_ready8); end
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (r8 !== 16'd408 || lat != 5) begin errors++; $display("[TB] FAIL bp_second got r=%0d lat=%0d want r=408 lat=5", r8, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] got;
        int lat;
        @(posedge clk); #1;
        a8 = 8'd200; b8 = 8'd100; mode8 = 2'b00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %0b want 0", out_valid8); end
        checks++; if (r8 !== 16'd0) begin errors++; $display("[TB] FAIL midrst_r got %0d want 0", r8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %0b want 1", in_ready8); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op8(8'd3, 8'd5, 2'b00, got, lat);
        checks++; if (got !== 16'd15 || lat != 5) begin errors++; $display("[TB] FAIL midrst_next got r=%0d lat=%0d want r=15 lat=5", got, lat); end
    endtask

    task automatic test_mode11_changes();
        int lat;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; mode8 = 2'b11; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (r8 !== 16'd65025) begin errors++; $display("[TB] FAIL mode11_latched got %0d want 65025", r8); end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL mode11_latency got %0d want 5", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; mode8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; mode16 = '0;
        test_reset();
        test_exact_w8();
        test_exact_w16();
        test_approx_directed();
        test_approx_random();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_mode11_changes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
